mux32_arbiter: RTL and testbench

Round-robin arbiter that shares one 32:1 mux read path among 32 requesters. It registers a one-hot grant and the matching 5-bit select, which drives the mux `sel` input directly. Each grant is held until the consumer acknowledges it. The rotating priority pointer guarantees that no requester starves.

---
 rtl/mux32_arbiter.sv | 102 ++++++++++
 tb/tb_mux32_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux32_arbiter.sv
// Round-robin arbiter for a shared 32:1 mux read path.
// Registers a one-hot grant plus its binary select; each grant is held until acked.
module mux32_arbiter #(
  parameter int N    = 32,
  parameter int SELW = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req,
  input  logic            ack,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] sel,
  output logic            gnt_valid
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [SELW-1:0] ptr, ptr_next;
  logic [N-1:0]    gnt_next;
  logic [SELW-1:0] sel_next;
  logic            gnt_valid_next;

  logic [SELW-1:0] base;
  logic [SELW-1:0] idx;
  logic [SELW-1:0] winner;
  logic            found;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ptr       <= '0;
      gnt       <= '0;
      sel       <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_next;
      ptr       <= ptr_next;
      gnt       <= gnt_next;
      sel       <= sel_next;
      gnt_valid <= gnt_valid_next;
    end
  end

  // On ack the search starts just past the served requester, which is the
  // same value ptr takes at this edge, so re-arbitration needs no extra cycle.
  always_comb begin
    base = (state == GRANT) ? sel + 1'b1 : ptr;
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < N; i++) begin
      idx = base + SELW'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    gnt_next       = gnt;
    sel_next       = sel;
    gnt_valid_next = gnt_valid;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_next       = N'(1) << winner;
          sel_next       = winner;
          gnt_valid_next = 1'b1;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          ptr_next = sel + 1'b1;
          if (found) begin
            gnt_next = N'(1) << winner;
            sel_next = winner;
          end else begin
            gnt_next       = '0;
            sel_next       = '0;
            gnt_valid_next = 1'b0;
            state_next     = IDLE;
          end
        end
      end
      default: begin
        state_next     = IDLE;
        gnt_next       = '0;
        sel_next       = '0;
        gnt_valid_next = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux32_arbiter.sv
// Directed self-checking bench for mux32_arbiter.
module tb_mux32_arbiter;

  logic        clk;
  logic        reset_n;
  logic [31:0] req;
  logic        ack;
  logic [31:0] gnt;
  logic [4:0]  sel;
  logic        gnt_valid;

  int tests_run;
  int tests_failed;

  mux32_arbiter #(.N(32), .SELW(5)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .ack      (ack),
    .gnt      (gnt),
    .sel      (sel),
    .gnt_valid(gnt_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    ack     = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    req     = 32'hFFFF_FFFF;
    ack     = 1'b0;
    #2;
    tests_run++;
    if (gnt !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_gnt got=%h exp=%h", gnt, 32'h0);
    end
    tests_run++;
    if (sel !== 5'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_sel got=%0d exp=0", sel);
    end
    tests_run++;
    if (gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_valid got=%b exp=0", gnt_valid);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req = 32'h0000_0001;
    ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      tests_run++;
      if (gnt !== 32'h1 || sel !== 5'd0 || gnt_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL single_hold cyc=%0d got gnt=%h sel=%0d v=%b exp gnt=1 sel=0 v=1",
                 c, gnt, sel, gnt_valid);
      end
    end
    req = '0;
    ack = 1'b1;
    step();
    tests_run++;
    if (gnt !== 32'h0 || sel !== 5'd0 || gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_release got gnt=%h sel=%0d v=%b exp gnt=0 sel=0 v=0",
               gnt, sel, gnt_valid);
    end
    ack = 1'b0;
  endtask

  task automatic test_saturation();
    logic [4:0]  exp_sel;
    logic [31:0] exp_gnt;
    do_reset();
    req = 32'hFFFF_FFFF;
    ack = 1'b1;
    for (int k = 0; k < 34; k++) begin
      step();
      exp_sel = 5'(k % 32);
      exp_gnt = 32'h1 << (k % 32);
      tests_run++;
      if (sel !== exp_sel || gnt !== exp_gnt || gnt_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL saturation k=%0d got sel=%0d gnt=%h v=%b exp sel=%0d gnt=%h v=1",
                 k, sel, gnt, gnt_valid, exp_sel, exp_gnt);
      end
    end
    req = '0;
    step();
    ack = 1'b0;
  endtask

  task automatic test_wrap();
    logic [4:0]  exp_sel [4];
    logic [31:0] exp_gnt [4];
    exp_sel[0] = 5'd4;  exp_gnt[0] = 32'h0000_0010;
    exp_sel[1] = 5'd31; exp_gnt[1] = 32'h8000_0000;
    exp_sel[2] = 5'd0;  exp_gnt[2] = 32'h0000_0001;
    exp_sel[3] = 5'd3;  exp_gnt[3] = 32'h0000_0008;
    do_reset();
    req = 32'h0000_0010;
    ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      tests_run++;
      if (sel !== exp_sel[k] || gnt !== exp_gnt[k] || gnt_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL wrap k=%0d got sel=%0d gnt=%h v=%b exp sel=%0d gnt=%h v=1",
                 k, sel, gnt, gnt_valid, exp_sel[k], exp_gnt[k]);
      end
      req = 32'h8000_0009;
      ack = 1'b1;
    end
    req = '0;
    step();
    ack = 1'b0;
  endtask

  task automatic test_withdrawal();
    do_reset();
    req = 32'h0000_0080;
    ack = 1'b0;
    step();
    tests_run++;
    if (sel !== 5'd7 || gnt !== 32'h80) begin
      tests_failed++;
      $display("[TB] FAIL withdraw_first got sel=%0d gnt=%h exp sel=7 gnt=80", sel, gnt);
    end
    req = 32'h0000_0200;
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if (sel !== 5'd7 || gnt !== 32'h80 || gnt_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL withdraw_hold cyc=%0d got sel=%0d gnt=%h v=%b exp sel=7 gnt=80 v=1",
                 c, sel, gnt, gnt_valid);
      end
    end
    ack = 1'b1;
    step();
    tests_run++;
    if (sel !== 5'd9 || gnt !== 32'h200 || gnt_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL withdraw_next got sel=%0d gnt=%h v=%b exp sel=9 gnt=200 v=1",
               sel, gnt, gnt_valid);
    end
    req = '0;
    step();
    ack = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 32'h0000_1000;
    ack = 1'b0;
    step();
    tests_run++;
    if (sel !== 5'd12 || gnt_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL areset_pre got sel=%0d v=%b exp sel=12 v=1", sel, gnt_valid);
    end
    #3;
    reset_n = 1'b0;
    #1;
    tests_run++;
    if (gnt !== 32'h0 || sel !== 5'd0 || gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL areset_clear got gnt=%h sel=%0d v=%b exp gnt=0 sel=0 v=0",
               gnt, sel, gnt_valid);
    end
    req = 32'h0000_2000;
    step();
    reset_n = 1'b1;
    tests_run++;
    if (gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL areset_held got v=%b exp v=0", gnt_valid);
    end
    step();
    tests_run++;
    if (sel !== 5'd13 || gnt !== 32'h2000 || gnt_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL areset_regrant got sel=%0d gnt=%h v=%b exp sel=13 gnt=2000 v=1",
               sel, gnt, gnt_valid);
    end
    req = '0;
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  task automatic test_ack_idle();
    do_reset();
    req = '0;
    ack = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      tests_run++;
      if (gnt !== 32'h0 || gnt_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL ack_idle cyc=%0d got gnt=%h v=%b exp gnt=0 v=0", c, gnt, gnt_valid);
      end
    end
    req = 32'h0000_0004;
    step();
    tests_run++;
    if (sel !== 5'd2 || gnt !== 32'h4 || gnt_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL ack_idle_grant got sel=%0d gnt=%h v=%b exp sel=2 gnt=4 v=1",
               sel, gnt, gnt_valid);
    end
    req = '0;
    step();
    ack = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n = 1'b1;
    req     = '0;
    ack     = 1'b0;
    test_reset();
    test_single();
    test_saturation();
    test_wrap();
    test_withdrawal();
    test_async_reset();
    test_ack_idle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
